// File: rtl/sram_mem_controller_pkg.sv
// Shared constants, state encoding and address helper for the SRAM MEM-stage controller.
package sram_mem_controller_pkg;

   localparam int REGISTER_LEN  = 32;
   localparam int SRAM_DATA_LEN = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Word index of a byte address relative to the SRAM base (modular, byte offset dropped).
   function automatic logic [REGISTER_LEN-1:0] word_of(
      input logic [REGISTER_LEN-1:0] address,
      input logic [REGISTER_LEN-1:0] base
   );
      logic [REGISTER_LEN-1:0] diff;
      diff = address - base;
      return {2'b00, diff[REGISTER_LEN-1:2]};
   endfunction

endpackage

// File: rtl/sram_mem_controller_wait_counter.sv
// Down-counter that times one half-word access: load WAIT_CYCLES-1, count to zero.
module sram_mem_controller_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic last
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic [CW-1:0] count;

   // Reload on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= {CW{1'b0}};
      end else if (load) begin
         count <= CW'(WAIT_CYCLES - 1);
      end else if (count != {CW{1'b0}}) begin
         count <= count - CW'(1);
      end else begin
         count <= count;
      end
   end

   assign last = (count == {CW{1'b0}});

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: one 32-bit load/store as two wait-stated 16-bit SRAM accesses.
// SRAM-side outputs are registered from the next state, so they change with the state.
// With WAIT_CYCLES=1 the high half of a write is only its setup cycle and never strobes.
module sram_mem_controller
   import sram_mem_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int          SRAM_AW     = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rd_en,
   input  logic                     wr_en,
   input  logic [REGISTER_LEN-1:0]  address,
   input  logic [REGISTER_LEN-1:0]  wdata,
   output logic [REGISTER_LEN-1:0]  rdata,
   output logic                     ready,
   output logic [SRAM_AW-1:0]       sram_addr,
   inout  wire  [SRAM_DATA_LEN-1:0] sram_dq,
   output logic                     sram_we_n
);

   state_t                   state;
   state_t                   next_state;
   logic                     op_write;
   logic [SRAM_AW-2:0]       word;
   logic [REGISTER_LEN-1:0]  wdata_l;
   logic [SRAM_DATA_LEN-1:0] rdata_lo;
   logic                     dq_oe;
   logic [SRAM_DATA_LEN-1:0] dq_out;
   logic                     request;
   logic                     cnt_load;
   logic                     cnt_last;
   logic                     cur_write;
   logic [SRAM_AW-2:0]       req_word;
   logic [SRAM_AW-2:0]       cur_word;
   logic [REGISTER_LEN-1:0]  cur_wdata;
   logic                     we_n_next;
   logic                     dq_oe_next;
   logic [SRAM_DATA_LEN-1:0] dq_out_next;
   logic [SRAM_AW-1:0]       addr_next;

   sram_mem_controller_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .last  (cnt_last)
   );

   assign request  = rd_en | wr_en;
   assign req_word = (SRAM_AW-1)'(word_of(address, BASE_ADDR));
   assign ready    = (state == ST_DONE) || ((state == ST_IDLE) && !request);
   assign sram_dq  = dq_oe ? dq_out : {SRAM_DATA_LEN{1'bz}};

   // Next-state logic and counter reload at the start of each half-word phase.
   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (request) begin
               next_state = ST_LOW;
               cnt_load   = 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_LOW: begin
            if (cnt_last) begin
               next_state = ST_HIGH;
               cnt_load   = 1'b1;
            end else begin
               next_state = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (cnt_last) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_HIGH;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // SRAM pin values for the coming cycle; in IDLE the live request is used, since it is
   // latched on the same edge. The first HIGH cycle of a write keeps we_n high for setup.
   always_comb begin
      cur_write   = (state == ST_IDLE) ? wr_en : op_write;
      cur_word    = (state == ST_IDLE) ? req_word : word;
      cur_wdata   = (state == ST_IDLE) ? wdata : wdata_l;
      we_n_next   = 1'b1;
      dq_oe_next  = 1'b0;
      dq_out_next = cur_wdata[SRAM_DATA_LEN-1:0];
      addr_next   = sram_addr;
      if (next_state == ST_LOW) begin
         addr_next = {cur_word, 1'b0};
      end else if (next_state == ST_HIGH) begin
         addr_next   = {cur_word, 1'b1};
         dq_out_next = cur_wdata[REGISTER_LEN-1:SRAM_DATA_LEN];
      end else begin
         addr_next = sram_addr;
      end
      if (cur_write && ((next_state == ST_LOW) || (next_state == ST_HIGH))) begin
         dq_oe_next = 1'b1;
      end else begin
         dq_oe_next = 1'b0;
      end
      if (cur_write && (next_state == state || state == ST_IDLE) &&
          ((next_state == ST_LOW) || (next_state == ST_HIGH))) begin
         we_n_next = 1'b0;
      end else begin
         we_n_next = 1'b1;
      end
   end

   // State, request latch, read-data capture and registered SRAM pins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_write  <= 1'b0;
         word      <= {(SRAM_AW-1){1'b0}};
         wdata_l   <= {REGISTER_LEN{1'b0}};
         rdata_lo  <= {SRAM_DATA_LEN{1'b0}};
         rdata     <= {REGISTER_LEN{1'b0}};
         sram_we_n <= 1'b1;
         sram_addr <= {SRAM_AW{1'b0}};
         dq_oe     <= 1'b0;
         dq_out    <= {SRAM_DATA_LEN{1'b0}};
      end else begin
         state     <= next_state;
         sram_we_n <= we_n_next;
         sram_addr <= addr_next;
         dq_oe     <= dq_oe_next;
         dq_out    <= dq_out_next;
         if ((state == ST_IDLE) && request) begin
            op_write <= wr_en;
            word     <= req_word;
            wdata_l  <= wdata;
         end
         if ((state == ST_LOW) && cnt_last && !op_write) begin
            rdata_lo <= sram_dq;
         end
         if ((state == ST_HIGH) && cnt_last && !op_write) begin
            rdata <= {sram_dq, rdata_lo};
         end
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized self-checking bench: word-level reference memory against a half-word SRAM model.
module tb_sram_mem_controller;

   localparam logic [31:0] BASE = 32'd1024;
   localparam int          W    = 5;
   localparam int          AW   = 18;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        ready;
   logic [AW-1:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n;

   logic [15:0] sram [0:(1<<AW)-1];
   logic        tb_oe = 1'b0;

   bit [31:0]   ref_mem [int unsigned];
   logic [31:0] exp_rdata = 32'd0;
   int          checks = 0;
   int          failures = 0;

   sram_mem_controller #(
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES (W),
      .SRAM_AW     (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .sram_addr (sram_addr),
      .sram_dq   (sram_dq),
      .sram_we_n (sram_we_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: drives data during reads, stores while we_n is low.
   assign sram_dq = tb_oe ? sram[sram_addr] : 16'bz;

   always @(negedge clk) begin
      if (sram_we_n == 1'b0) sram[sram_addr] <= sram_dq;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned ref_key(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off / 4) % (1 << (AW - 1));
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      int unsigned k;
      k = ref_key(a);
      return ref_mem.exists(k) ? ref_mem[k] : 32'd0;
   endfunction

   // One full transaction: present request, count stalled cycles, check result in DONE.
   task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      wr_en = w; rd_en = r; address = a; wdata = d;
      tb_oe = r && !w;
      #1;
      n = 0;
      while (!ready && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("latency", n, 2*W+1);
      if (w) ref_mem[ref_key(a)] = d;
      else   exp_rdata = ref_read(a);
      check("rdata", rdata, exp_rdata);
      tb_oe = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr_en = 1'b0; rd_en = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          kind;
      for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0000;

      // Reset held two cycles with a read pending.
      rd_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdata", rdata, 32'd0);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_addr", {14'd0, sram_addr}, 32'd0);
      rst_n = 1'b1; rd_en = 1'b0;
      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);

      // Store then load of the same word.
      do_op(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
      check("mem_lo", {16'd0, sram[2]}, 32'h0000_BEEF);
      check("mem_hi", {16'd0, sram[3]}, 32'h0000_DEAD);
      idle(1);
      do_op(1'b0, 1'b1, 32'd1028, 32'd0);
      check("load_val", rdata, 32'hDEAD_BEEF);
      idle(3);
      check("rdata_held", rdata, 32'hDEAD_BEEF);

      // Back-to-back store and load without an idle gap.
      do_op(1'b1, 1'b0, 32'd1024, 32'h0000_0001);
      do_op(1'b0, 1'b1, 32'd1024, 32'd0);
      check("b2b_val", rdata, 32'h0000_0001);
      idle(1);

      // Reset during the setup cycle of the high half of a write.
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1032; wdata = 32'hCAFE_F00D;
      repeat (W+1) @(negedge clk);
      rst_n = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      #1;
      check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      exp_rdata = 32'd0;
      ref_mem[ref_key(32'd1032)] = {ref_read(32'd1032) & 32'hFFFF_0000} | 32'h0000_F00D;
      do_op(1'b0, 1'b1, 32'd1032, 32'd0);
      check("abort_val", rdata, 32'h0000_F00D);
      idle(1);

      // Both enables asserted: behaves as a write, rdata untouched.
      do_op(1'b1, 1'b1, 32'd1024 + 32'd4*32'd7, 32'h1234_5678);
      idle(1);
      do_op(1'b0, 1'b1, 32'd1024 + 32'd4*32'd7, 32'd0);
      check("both_val", rdata, 32'h1234_5678);

      // Randomized mix of loads, stores and conflicting requests, with wrap-around addresses.
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 4);
         if ($urandom_range(0, 1) == 0) a = BASE + 32'd4*$urandom_range(0, 7) + $urandom_range(0, 3);
         else                           a = $urandom;
         d = $urandom;
         case (kind)
            0, 1:    do_op(1'b1, 1'b0, a, d);
            2, 3:    do_op(1'b0, 1'b1, a, d);
            default: do_op(1'b1, 1'b1, a, d);
         endcase
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
